// File: rtl/segment_display_driver_pkg.sv
// Shared symbol codes, segment patterns, digit positions and the status snapshot layout
// for the irrigation status display.
package segment_display_driver_pkg;

  // Symbol codes fed to the encoder; values 0..7 are the decimal digits themselves.
  typedef enum logic [3:0] {
    SYM_0       = 4'd0,
    SYM_1       = 4'd1,
    SYM_2       = 4'd2,
    SYM_3       = 4'd3,
    SYM_4       = 4'd4,
    SYM_5       = 4'd5,
    SYM_6       = 4'd6,
    SYM_7       = 4'd7,
    SYM_E       = 4'd8,
    SYM_S       = 4'd9,
    SYM_LOWER_D = 4'd10,
    SYM_DASH    = 4'd11,
    SYM_LOWER_U = 4'd12,
    SYM_F       = 4'd13,
    SYM_C       = 4'd14,
    SYM_BLANK   = 4'd15
  } symbol_e;

  // Active-low {g,f,e,d,c,b,a} patterns for a common-anode display.
  localparam logic [6:0] SEG_0       = 7'h40;
  localparam logic [6:0] SEG_1       = 7'h79;
  localparam logic [6:0] SEG_2       = 7'h24;
  localparam logic [6:0] SEG_3       = 7'h30;
  localparam logic [6:0] SEG_4       = 7'h19;
  localparam logic [6:0] SEG_5       = 7'h12;
  localparam logic [6:0] SEG_6       = 7'h02;
  localparam logic [6:0] SEG_7       = 7'h78;
  localparam logic [6:0] SEG_E       = 7'h06;
  localparam logic [6:0] SEG_S       = 7'h12;
  localparam logic [6:0] SEG_LOWER_D = 7'h21;
  localparam logic [6:0] SEG_DASH    = 7'h3F;
  localparam logic [6:0] SEG_LOWER_U = 7'h63;
  localparam logic [6:0] SEG_F       = 7'h0E;
  localparam logic [6:0] SEG_C       = 7'h46;
  localparam logic [6:0] SEG_BLANK   = 7'h7F;

  // Physical digit positions; index 3 is the last slot of a frame.
  localparam logic [1:0] DIGIT_LEVEL = 2'd0;
  localparam logic [1:0] DIGIT_FLOW  = 2'd1;
  localparam logic [1:0] DIGIT_FERT  = 2'd2;
  localparam logic [1:0] DIGIT_MODE  = 2'd3;

  // One frame's worth of captured irrigation status.
  typedef struct packed {
    logic [2:0] waterLevel;
    logic       watering;
    logic       filling;
    logic       splinker;
    logic       dripper;
    logic       fertilising;
    logic       cleaning;
    logic       inputError;
  } status_t;

  // Tank level 0..7 maps straight onto the numeric symbol codes.
  function automatic symbol_e levelSymbol(input logic [2:0] level);
    return symbol_e'({1'b0, level});
  endfunction

endpackage

// File: rtl/segment_display_driver_encoder.sv
// Combinational symbol-code to active-low seven-segment pattern decoder.
module segment_display_driver_encoder
  import segment_display_driver_pkg::*;
(
  input  logic [3:0] sym_i,
  output logic [6:0] seg_o
);

  // Look up the segment pattern for the requested symbol.
  always_comb begin
    seg_o = SEG_BLANK;
    case (symbol_e'(sym_i))
      SYM_0:       seg_o = SEG_0;
      SYM_1:       seg_o = SEG_1;
      SYM_2:       seg_o = SEG_2;
      SYM_3:       seg_o = SEG_3;
      SYM_4:       seg_o = SEG_4;
      SYM_5:       seg_o = SEG_5;
      SYM_6:       seg_o = SEG_6;
      SYM_7:       seg_o = SEG_7;
      SYM_E:       seg_o = SEG_E;
      SYM_S:       seg_o = SEG_S;
      SYM_LOWER_D: seg_o = SEG_LOWER_D;
      SYM_DASH:    seg_o = SEG_DASH;
      SYM_LOWER_U: seg_o = SEG_LOWER_U;
      SYM_F:       seg_o = SEG_F;
      SYM_C:       seg_o = SEG_C;
      SYM_BLANK:   seg_o = SEG_BLANK;
      default:     seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/segment_display_driver.sv
// Four-digit multiplexed status display for the irrigation controller. Inputs are
// snapshotted once per frame so a frame never mixes old and new status; every digit
// slot starts with a short all-off window to suppress ghosting between digits.
module segment_display_driver
  import segment_display_driver_pkg::*;
#(
  parameter int SCAN_DIVIDER = 1000,
  parameter int BLANK_CYCLES = 8,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clock,
  input  logic       reset_button,
  input  logic [2:0] water_level,
  input  logic       watering,
  input  logic       filling,
  input  logic       splinker,
  input  logic       dripper,
  input  logic       fertilising,
  input  logic       cleaning,
  input  logic       input_error,
  output logic [6:0] segments,
  output logic       decimal_point,
  output logic [3:0] digit_select
);

  localparam int PRESC_W = (SCAN_DIVIDER > 1) ? $clog2(SCAN_DIVIDER) : 1;
  localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIVIDER - 1);
  localparam logic [PRESC_W-1:0] BLANK_END  = PRESC_W'(BLANK_CYCLES);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

  logic [PRESC_W-1:0] prescaler_q, prescaler_d;
  logic [1:0]         digitIdx_q, digitIdx_d;
  logic [FRAME_W-1:0] frameCount_q, frameCount_d;
  logic               blinkPhase_q, blinkPhase_d;
  status_t            snapshot_q, snapshot_d;
  logic [6:0]         segments_q, segments_d;
  logic               decimalPoint_q, decimalPoint_d;
  logic [3:0]         digitSelect_q, digitSelect_d;

  status_t            liveStatus;
  logic               slotEnd;
  logic               frameEnd;
  logic               inBlankTime;
  logic               errorBlank;
  logic               levelCritical;
  symbol_e            digitSym;
  logic [6:0]         encodedSeg;

  // Gather the live inputs into the snapshot layout.
  always_comb begin
    liveStatus.waterLevel  = water_level;
    liveStatus.watering    = watering;
    liveStatus.filling     = filling;
    liveStatus.splinker    = splinker;
    liveStatus.dripper     = dripper;
    liveStatus.fertilising = fertilising;
    liveStatus.cleaning    = cleaning;
    liveStatus.inputError  = input_error;
  end

  // Advance the slot prescaler, digit index, frame counter, blink phase and snapshot.
  always_comb begin
    slotEnd      = (prescaler_q == PRESC_LAST);
    frameEnd     = slotEnd && (digitIdx_q == DIGIT_MODE);
    prescaler_d  = slotEnd ? '0 : prescaler_q + PRESC_W'(1);
    digitIdx_d   = slotEnd ? digitIdx_q + 2'd1 : digitIdx_q;
    frameCount_d = frameCount_q;
    blinkPhase_d = blinkPhase_q;
    snapshot_d   = snapshot_q;
    if (frameEnd) begin
      snapshot_d = liveStatus;
      if (frameCount_q == FRAME_LAST) begin
        frameCount_d = '0;
        blinkPhase_d = ~blinkPhase_q;
      end else begin
        frameCount_d = frameCount_q + FRAME_W'(1);
      end
    end
  end

  // Choose the symbol for the digit currently being scanned from the frozen snapshot.
  always_comb begin
    digitSym = SYM_BLANK;
    case (digitIdx_q)
      DIGIT_MODE: begin
        if (snapshot_q.inputError)    digitSym = SYM_E;
        else if (snapshot_q.splinker) digitSym = SYM_S;
        else if (snapshot_q.dripper)  digitSym = SYM_LOWER_D;
        else                          digitSym = SYM_DASH;
      end
      DIGIT_FERT: begin
        if (snapshot_q.fertilising)   digitSym = SYM_F;
        else if (snapshot_q.cleaning) digitSym = SYM_C;
        else                          digitSym = SYM_BLANK;
      end
      DIGIT_FLOW: begin
        if (snapshot_q.filling)       digitSym = SYM_LOWER_U;
        else if (snapshot_q.watering) digitSym = SYM_LOWER_D;
        else                          digitSym = SYM_DASH;
      end
      default: digitSym = levelSymbol(snapshot_q.waterLevel);
    endcase
  end

  segment_display_driver_encoder u_encoder (
    .sym_i (digitSym),
    .seg_o (encodedSeg)
  );

  // Apply ghosting blank time, error blink and low-tank decimal point to the next outputs.
  always_comb begin
    inBlankTime    = (prescaler_q < BLANK_END);
    errorBlank     = snapshot_q.inputError && blinkPhase_q;
    levelCritical  = (snapshot_q.waterLevel <= 3'd1);
    segments_d     = SEG_BLANK;
    decimalPoint_d = 1'b1;
    digitSelect_d  = 4'hF;
    if (!inBlankTime && !errorBlank) begin
      segments_d    = encodedSeg;
      digitSelect_d = ~(4'b0001 << digitIdx_q);
      if ((digitIdx_q == DIGIT_LEVEL) && levelCritical && !blinkPhase_q) begin
        decimalPoint_d = 1'b0;
      end
    end
  end

  // Register scan state and outputs; a low reset_button blanks the display and restarts the scan.
  always_ff @(posedge clock) begin
    if (!reset_button) begin
      prescaler_q    <= '0;
      digitIdx_q     <= DIGIT_LEVEL;
      frameCount_q   <= '0;
      blinkPhase_q   <= 1'b0;
      snapshot_q     <= '0;
      segments_q     <= SEG_BLANK;
      decimalPoint_q <= 1'b1;
      digitSelect_q  <= 4'hF;
    end else begin
      prescaler_q    <= prescaler_d;
      digitIdx_q     <= digitIdx_d;
      frameCount_q   <= frameCount_d;
      blinkPhase_q   <= blinkPhase_d;
      snapshot_q     <= snapshot_d;
      segments_q     <= segments_d;
      decimalPoint_q <= decimalPoint_d;
      digitSelect_q  <= digitSelect_d;
    end
  end

  assign segments      = segments_q;
  assign decimal_point = decimalPoint_q;
  assign digit_select  = digitSelect_q;

endmodule
